dff_bank_wr_arbiter: RTL and testbench

- Round-robin write arbiter and enable sequencer for a bank of NUM_LANES registers, each WIDTH bits wide.
- NUM_REQ requesters share one write port into the bank. The block grants one requester per cycle and converts its lane address into a one-hot lane enable, so no lane ever sees a request-driven enable directly.
- Used in the verification suite to exercise enable sequencing on register banks under contention.

---
 rtl/dff_bank_wr_arbiter.sv | 108 ++++++++++
 tb/tb_dff_bank_wr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_wr_arbiter.sv
// rtl/dff_bank_wr_arbiter.sv - round-robin write arbiter driving a one-hot enabled register bank
// Optional per-lane write lock: define DFF_BANK_WR_LOCK_EN.
module dff_bank_wr_arbiter #(
  parameter int               NUM_REQ   = 4,
  parameter int               NUM_LANES = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  parameter int               AW        = 4
) (
  input  logic                       clk_i,
  input  logic                       sr_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*AW-1:0]      addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata_i,
`ifdef DFF_BANK_WR_LOCK_EN
  input  logic [NUM_LANES-1:0]       lock_i,
`endif
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       err_o,
  output logic [NUM_LANES-1:0]       lane_en_o,
  output logic [NUM_LANES*WIDTH-1:0] q_o
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]              ptr_q, ptr_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic                       wr_valid_q, wr_valid_d;
  logic [AW-1:0]              wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]           wr_data_q, wr_data_d;
  logic [NUM_LANES*WIDTH-1:0] q_q, q_d;
  logic [NUM_REQ-1:0]         cand;
  logic [NUM_LANES-1:0]       lane_en;

  // A requester still showing its grant is masked so a slow req drop cannot double-grant.
  assign cand = req_i & ~gnt_q;

  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = '0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!wr_valid_d && cand[i] && i >= int'(ptr_q)) begin
        wr_valid_d = 1'b1;
        gnt_d[i]   = 1'b1;
        wr_addr_d  = addr_i[i*AW +: AW];
        wr_data_d  = wdata_i[i*WIDTH +: WIDTH];
        ptr_d      = (i == NUM_REQ-1) ? '0 : PW'(i+1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!wr_valid_d && cand[i] && i < int'(ptr_q)) begin
        wr_valid_d = 1'b1;
        gnt_d[i]   = 1'b1;
        wr_addr_d  = addr_i[i*AW +: AW];
        wr_data_d  = wdata_i[i*WIDTH +: WIDTH];
        ptr_d      = (i == NUM_REQ-1) ? '0 : PW'(i+1);
      end
    end
  end

  // Out-of-range addresses match no lane, which is what flags them as dropped.
  always_comb begin
    lane_en = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_en[k] = wr_valid_q && (wr_addr_q == AW'(k));
    end
`ifdef DFF_BANK_WR_LOCK_EN
    if ((lane_en & lock_i) != '0) begin
      lane_en = '0;
    end
`endif
  end

  always_comb begin
    q_d = q_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_en[k]) begin
        q_d[k*WIDTH +: WIDTH] = wr_data_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sr_i) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      q_q        <= {NUM_LANES{INIT_VAL}};
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      q_q        <= q_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign err_o     = wr_valid_q && (lane_en == '0);
  assign lane_en_o = lane_en;
  assign q_o       = q_q;

endmodule

// File: tb/tb_dff_bank_wr_arbiter.sv
// tb/tb_dff_bank_wr_arbiter.sv - scoreboard bench for dff_bank_wr_arbiter
module tb_dff_bank_wr_arbiter;
  localparam logic [7:0] INIT = 8'hA5;

  logic        clk = 1'b0;
  logic        sr = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        err;
  logic [3:0]  lane_en;
  logic [31:0] q;

  dff_bank_wr_arbiter #(
    .NUM_REQ(4), .NUM_LANES(4), .WIDTH(8), .INIT_VAL(INIT), .AW(4)
  ) dut (
    .clk_i(clk),
    .sr_i(sr),
    .req_i(req),
    .addr_i(addr),
    .wdata_i(wdata),
`ifdef DFF_BANK_WR_LOCK_EN
    .lock_i(4'b0000),
`endif
    .gnt_o(gnt),
    .err_o(err),
    .lane_en_o(lane_en),
    .q_o(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic        err;
    logic [3:0]  lane_en;
    logic [31:0] q;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] mq;
  logic [31:0] pend_q;
  bit          pend_v = 0;
  bit          mon_en = 0;
  bit          chk_rst = 0;
  bit          done = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [7:0] d);
    addr[r*4 +: 4]  = a;
    wdata[r*8 +: 8] = d;
    req[r]          = 1'b1;
  endtask

  task automatic expect_wr(input int r, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    int   ai;
    ai        = int'(a);
    e.gnt     = 4'b0001 << r;
    e.err     = (ai >= 4);
    e.lane_en = (ai < 4) ? (4'b0001 << ai) : 4'b0000;
    if (ai < 4) mq[ai*8 +: 8] = d;
    e.q = mq;
    exp_q.push_back(e);
  endtask

  task automatic expect_rst_wr(input int r, input int lane);
    exp_t e;
    e.gnt     = 4'b0001 << r;
    e.err     = 1'b0;
    e.lane_en = 4'b0001 << lane;
    mq        = {4{INIT}};
    e.q       = mq;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_rst) begin
        check("rst_q", q, {4{INIT}});
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_lane_en", 32'(lane_en), 32'd0);
      end
      if (pend_v) begin
        check("q_after_wr", q, pend_q);
        pend_v = 0;
      end
      if (gnt !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(cur.gnt));
          check("err", 32'(err), 32'(cur.err));
          check("lane_en", 32'(lane_en), 32'(cur.lane_en));
          pend_q = cur.q;
          pend_v = 1;
        end
      end else if (!chk_rst) begin
        check("idle_err", 32'(err), 32'd0);
        check("idle_lane_en", 32'(lane_en), 32'd0);
      end
      if (done) begin
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    mq    = {4{INIT}};
    sr    = 1'b1;
    req   = 4'b1111;
    addr  = {4'd3, 4'd2, 4'd1, 4'd0};
    wdata = {8'h43, 8'h32, 8'h21, 8'h10};
    tick;
    mon_en  = 1;
    chk_rst = 1;
    tick;
    chk_rst = 0;
    sr      = 1'b0;
    expect_wr(0, 4'd0, 8'h10);
    expect_wr(1, 4'd1, 8'h21);
    expect_wr(2, 4'd2, 8'h32);
    expect_wr(3, 4'd3, 8'h43);
    tick;
    tick; req[0] = 1'b0;
    tick; req[1] = 1'b0;
    tick; req[2] = 1'b0;
    tick; req[3] = 1'b0;
    tick;
    tick;

    set_req(2, 4'd3, 8'h3C);
    expect_wr(2, 4'd3, 8'h3C);
    tick;
    tick; req[2] = 1'b0;
    tick;
    tick;

    set_req(3, 4'd2, 8'h6B);
    set_req(0, 4'd0, 8'h5A);
    expect_wr(3, 4'd2, 8'h6B);
    expect_wr(0, 4'd0, 8'h5A);
    tick;
    tick; req[3] = 1'b0;
    tick; req[0] = 1'b0;
    tick;
    tick;

    set_req(3, 4'd5, 8'hEE);
    expect_wr(3, 4'd5, 8'hEE);
    tick;
    tick; req[3] = 1'b0;
    tick;
    tick;

    set_req(0, 4'd1, 8'h11);
    set_req(1, 4'd1, 8'h22);
    expect_wr(0, 4'd1, 8'h11);
    expect_wr(1, 4'd1, 8'h22);
    tick;
    tick; req[0] = 1'b0;
    tick; req[1] = 1'b0;
    tick;
    tick;

    set_req(1, 4'd0, 8'h77);
    expect_rst_wr(1, 0);
    tick;
    sr     = 1'b1;
    req[1] = 1'b0;
    tick;
    sr = 1'b0;
    tick;
    tick;

    set_req(1, 4'd2, 8'h99);
    set_req(3, 4'd1, 8'h88);
    expect_wr(1, 4'd2, 8'h99);
    expect_wr(3, 4'd1, 8'h88);
    tick;
    tick; req[1] = 1'b0;
    tick; req[3] = 1'b0;
    tick;
    tick;
    done = 1;
  end

endmodule
